// File: rtl/tvr_scan_ctrl.sv
// FM channel scanner: retunes, settles, averages the demodulator magnitude over a window
// and locks onto the first channel whose average beats the carrier-detect threshold.
module tvr_scan_ctrl #(
  parameter int CH_NUM     = 16,
  parameter int SETTLE_CYC = 256,
  parameter int AVG_LOG2   = 6,
  parameter int HOLD_WIN   = 4
) (
  input  logic                      clk_in,
  input  logic                      RST,
  input  logic                      scan_en,
  input  logic                      sample_valid,
  input  logic [11:0]               modulo,
  input  logic [23:0]               thr_gate,
  output logic [$clog2(CH_NUM)-1:0] ch_sel,
  output logic                      ch_load,
  output logic [23:0]               avg_data,
  output logic                      fm_exist,
  output logic                      audio_mute,
  output logic                      busy
);

  localparam int CH_W   = $clog2(CH_NUM);
  localparam int ST_W   = $clog2(SETTLE_CYC + 1);
  localparam int SMP_W  = AVG_LOG2;
  localparam int MISS_W = $clog2(HOLD_WIN + 1);

  localparam logic [ST_W-1:0]   SETTLE_LAST = ST_W'(SETTLE_CYC - 1);
  localparam logic [SMP_W-1:0]  SMP_LAST    = '1;
  localparam logic [MISS_W-1:0] MISS_LAST   = MISS_W'(HOLD_WIN - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TUNE    = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_DECIDE  = 3'd4;
  localparam logic [2:0] S_LOCK    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
  logic              ch_load_q, ch_load_d;
  logic [23:0]       avg_data_q, avg_data_d;
  logic              fm_exist_q, fm_exist_d;
  logic              audio_mute_q, audio_mute_d;
  logic              busy_q, busy_d;
  logic [ST_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [SMP_W-1:0]  smp_cnt_q, smp_cnt_d;
  logic [23:0]       acc_q, acc_d;
  logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [23:0] acc_sum;
  logic [23:0] win_avg;
  logic        win_good;
  logic        win_done;

  // The sample arriving on the completing cycle is folded into that window's average.
  assign acc_sum  = acc_q + {12'd0, modulo};
  assign win_avg  = acc_sum >> AVG_LOG2;
  assign win_good = (win_avg > thr_gate);
  assign win_done = sample_valid && (smp_cnt_q == SMP_LAST);

  always_comb begin
    state_d      = state_q;
    ch_sel_d     = ch_sel_q;
    avg_data_d   = avg_data_q;
    fm_exist_d   = fm_exist_q;
    settle_cnt_d = settle_cnt_q;
    smp_cnt_d    = smp_cnt_q;
    acc_d        = acc_q;
    miss_cnt_d   = miss_cnt_q;

    if (!scan_en) begin
      state_d      = S_IDLE;
      fm_exist_d   = 1'b0;
      settle_cnt_d = '0;
      smp_cnt_d    = '0;
      acc_d        = '0;
      miss_cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_TUNE;

        S_TUNE: begin
          settle_cnt_d = '0;
          smp_cnt_d    = '0;
          acc_d        = '0;
          state_d      = S_SETTLE;
        end

        S_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d = S_MEASURE;
          end else begin
            settle_cnt_d = settle_cnt_q + ST_W'(1);
          end
        end

        S_MEASURE: begin
          if (sample_valid) begin
            acc_d     = acc_sum;
            smp_cnt_d = smp_cnt_q + SMP_W'(1);
            if (win_done) begin
              avg_data_d = win_avg;
              state_d    = S_DECIDE;
            end
          end
        end

        S_DECIDE: begin
          acc_d      = '0;
          smp_cnt_d  = '0;
          miss_cnt_d = '0;
          if (avg_data_q > thr_gate) begin
            state_d    = S_LOCK;
            fm_exist_d = 1'b1;
          end else begin
            ch_sel_d = ch_sel_q + CH_W'(1);
            state_d  = S_TUNE;
          end
        end

        // Locked windows run back to back; a run of weak windows releases the channel.
        S_LOCK: begin
          if (win_done) begin
            avg_data_d = win_avg;
            acc_d      = '0;
            smp_cnt_d  = '0;
            if (win_good) begin
              miss_cnt_d = '0;
            end else if (miss_cnt_q == MISS_LAST) begin
              miss_cnt_d = '0;
              fm_exist_d = 1'b0;
              ch_sel_d   = ch_sel_q + CH_W'(1);
              state_d    = S_TUNE;
            end else begin
              miss_cnt_d = miss_cnt_q + MISS_W'(1);
            end
          end else if (sample_valid) begin
            acc_d     = acc_sum;
            smp_cnt_d = smp_cnt_q + SMP_W'(1);
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    ch_load_d    = (state_d == S_TUNE);
    busy_d       = (state_d != S_IDLE);
    audio_mute_d = ~fm_exist_d;
  end

  always_ff @(posedge clk_in) begin
    if (RST) begin
      state_q      <= S_IDLE;
      ch_sel_q     <= '0;
      ch_load_q    <= 1'b0;
      avg_data_q   <= '0;
      fm_exist_q   <= 1'b0;
      audio_mute_q <= 1'b1;
      busy_q       <= 1'b0;
      settle_cnt_q <= '0;
      smp_cnt_q    <= '0;
      acc_q        <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      ch_sel_q     <= ch_sel_d;
      ch_load_q    <= ch_load_d;
      avg_data_q   <= avg_data_d;
      fm_exist_q   <= fm_exist_d;
      audio_mute_q <= audio_mute_d;
      busy_q       <= busy_d;
      settle_cnt_q <= settle_cnt_d;
      smp_cnt_q    <= smp_cnt_d;
      acc_q        <= acc_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign ch_sel     = ch_sel_q;
  assign ch_load    = ch_load_q;
  assign avg_data   = avg_data_q;
  assign fm_exist   = fm_exist_q;
  assign audio_mute = audio_mute_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_tvr_scan_ctrl.sv
// Bench for tvr_scan_ctrl: directed scenarios queue the ch_load and fm_exist events they
// should produce; a negedge monitor pops and checks each event as the DUT raises it.
module tb_tvr_scan_ctrl;

  logic        clk_in = 1'b0;
  logic        RST;
  logic        scan_en;
  logic        sample_valid;
  logic [11:0] modulo;
  logic [23:0] thr_gate;
  logic [1:0]  ch_sel;
  logic        ch_load;
  logic [23:0] avg_data;
  logic        fm_exist;
  logic        audio_mute;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    bit is_fm;
    int at;
    int ch;
    bit fm;
    int avg;
    bit chk_avg;
  } exp_t;

  exp_t expq[$];

  bit prev_fm   = 1'b0;
  bit prev_load = 1'b0;

  tvr_scan_ctrl #(
    .CH_NUM(4),
    .SETTLE_CYC(8),
    .AVG_LOG2(2),
    .HOLD_WIN(2)
  ) dut (
    .clk_in(clk_in),
    .RST(RST),
    .scan_en(scan_en),
    .sample_valid(sample_valid),
    .modulo(modulo),
    .thr_gate(thr_gate),
    .ch_sel(ch_sel),
    .ch_load(ch_load),
    .avg_data(avg_data),
    .fm_exist(fm_exist),
    .audio_mute(audio_mute),
    .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit en, input bit vld,
                               input int mod, input int thr);
    RST          = rst;
    scan_en      = en;
    sample_valid = vld;
    modulo       = 12'(mod);
    thr_gate     = 24'(thr);
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic push(input bit is_fm, input int at, input int ch, input bit fm,
                      input int avg, input bit chk_avg);
    exp_t e;
    e.is_fm   = is_fm;
    e.at      = at;
    e.ch      = ch;
    e.fm      = fm;
    e.avg     = avg;
    e.chk_avg = chk_avg;
    expq.push_back(e);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expq.size() != 0 && n < budget) begin
      run(1);
      n++;
    end
    checkOutput("pending_events", expq.size(), 0);
    expq.delete();
  endtask

  task automatic doReset(input bit was_locked);
    if (was_locked) push(1'b1, -1, 0, 1'b0, 0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 100, 50);
    run(2);
    waitDrain(4);
  endtask

  task automatic handleEvent(input bit is_fm);
    exp_t e;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event: got %s event, expected none (cycle %0d)",
               is_fm ? "fm_exist" : "ch_load", cyc);
      return;
    end
    e = expq.pop_front();
    checkOutput(is_fm ? "event_kind_fm" : "event_kind_load", 32'(is_fm), 32'(e.is_fm));
    if (is_fm != e.is_fm) return;
    if (e.at >= 0) checkOutput("event_cycle", cyc, e.at);
    checkOutput("event_ch_sel", ch_sel, e.ch);
    if (e.chk_avg) checkOutput("event_avg_data", avg_data, e.avg);
    if (is_fm) begin
      checkOutput("fm_exist", fm_exist, 32'(e.fm));
      checkOutput("audio_mute", audio_mute, 32'(!e.fm));
    end else begin
      checkOutput("load_busy", busy, 1);
      checkOutput("load_not_consecutive", 32'(prev_load), 0);
      checkOutput("load_fm_exist", fm_exist, 0);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk_in) begin
    cyc++;
    if (fm_exist !== prev_fm) handleEvent(1'b1);
    if (ch_load === 1'b1) handleEvent(1'b0);
    prev_fm   = fm_exist;
    prev_load = ch_load;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, expected to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int vals[4];
    vals[0] = 40; vals[1] = 60; vals[2] = 80; vals[3] = 100;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b1, 100, 50);
    run(2);
    checkOutput("rst_ch_sel", ch_sel, 0);
    checkOutput("rst_ch_load", ch_load, 0);
    checkOutput("rst_avg_data", avg_data, 0);
    checkOutput("rst_fm_exist", fm_exist, 0);
    checkOutput("rst_audio_mute", audio_mute, 1);
    checkOutput("rst_busy", busy, 0);

    // Strong carrier on ch 0: lock after 1+8+4+1 cycles, then no more retunes
    $display("[TB] scenario: lock on first channel");
    base = cyc + 1;
    push(1'b0, base + 1, 0, 1'b0, 0, 1'b1);
    push(1'b1, base + 15, 0, 1'b1, 100, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 100, 50);
    waitDrain(40);
    run(20);
    checkOutput("lock_held_fm_exist", fm_exist, 1);

    // Lock, then bad / good / bad / bad windows: the good one restarts the miss count
    $display("[TB] scenario: loss of carrier in lock");
    doReset(1'b1);
    base = cyc + 1;
    push(1'b0, base + 1, 0, 1'b0, 0, 1'b1);
    push(1'b1, base + 15, 0, 1'b1, 100, 1'b1);
    push(1'b1, base + 35, 1, 1'b0, 10, 1'b1);
    push(1'b0, base + 35, 1, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 100, 50);
    run(19);
    applyStimulus(1'b0, 1'b1, 1'b1, 10, 50);
    run(4);
    applyStimulus(1'b0, 1'b1, 1'b1, 100, 50);
    run(4);
    applyStimulus(1'b0, 1'b1, 1'b1, 10, 50);
    waitDrain(40);
    applyStimulus(1'b0, 1'b0, 1'b1, 10, 50);
    run(2);

    // No carrier anywhere: channel index walks and wraps every 14 cycles
    $display("[TB] scenario: scan with wrap");
    doReset(1'b0);
    base = cyc + 1;
    push(1'b0, base + 1, 0, 1'b0, 0, 1'b1);
    push(1'b0, base + 15, 1, 1'b0, 10, 1'b1);
    push(1'b0, base + 29, 2, 1'b0, 10, 1'b1);
    push(1'b0, base + 43, 3, 1'b0, 10, 1'b1);
    push(1'b0, base + 57, 0, 1'b0, 10, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 10, 50);
    waitDrain(80);
    applyStimulus(1'b0, 1'b0, 1'b1, 10, 50);
    run(2);

    // Average equal to threshold does not lock; one above does
    $display("[TB] scenario: threshold boundary");
    doReset(1'b0);
    base = cyc + 1;
    push(1'b0, base + 1, 0, 1'b0, 0, 1'b1);
    push(1'b0, base + 15, 1, 1'b0, 50, 1'b1);
    push(1'b1, base + 29, 1, 1'b1, 51, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 50, 50);
    run(20);
    applyStimulus(1'b0, 1'b1, 1'b1, 51, 50);
    waitDrain(40);

    // Settle ignores samples; gaps in sample_valid stretch the window
    $display("[TB] scenario: gapped samples");
    doReset(1'b1);
    base = cyc + 1;
    push(1'b0, base + 1, 0, 1'b0, 0, 1'b1);
    push(1'b1, base + 18, 0, 1'b1, 70, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 200, 50);
    run(10);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, (i % 2) == 0, ((i % 2) == 0) ? vals[i / 2] : 250, 50);
      run(1);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 100, 50);
    waitDrain(30);

    // scan_en drop mid-settle keeps ch_sel and avg_data
    $display("[TB] scenario: scan_en abort and reset abort");
    doReset(1'b1);
    base = cyc + 1;
    push(1'b0, base + 1, 0, 1'b0, 0, 1'b1);
    push(1'b0, base + 15, 1, 1'b0, 10, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 10, 50);
    run(18);
    applyStimulus(1'b0, 1'b0, 1'b1, 10, 50);
    run(1);
    waitDrain(4);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_ch_sel", ch_sel, 1);
    checkOutput("abort_avg_data", avg_data, 10);
    checkOutput("abort_audio_mute", audio_mute, 1);
    run(3);

    // Resume on ch 1, lock, then reset mid-window while scan_en stays high
    base = cyc + 1;
    push(1'b0, base + 1, 1, 1'b0, 10, 1'b1);
    push(1'b1, base + 15, 1, 1'b1, 100, 1'b1);
    push(1'b1, base + 18, 0, 1'b0, 0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 100, 50);
    run(17);
    applyStimulus(1'b1, 1'b1, 1'b1, 100, 50);
    run(1);
    checkOutput("rst_lock_ch_sel", ch_sel, 0);
    checkOutput("rst_lock_avg_data", avg_data, 0);
    checkOutput("rst_lock_busy", busy, 0);
    checkOutput("rst_lock_ch_load", ch_load, 0);
    run(2);
    checkOutput("rst_override_busy", busy, 0);

    // Release with scan_en high: TUNE on ch 0 at the next edge, fresh window
    base = cyc + 1;
    push(1'b0, base + 1, 0, 1'b0, 0, 1'b1);
    push(1'b1, base + 15, 0, 1'b1, 100, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 100, 50);
    waitDrain(40);

    push(1'b1, -1, 0, 1'b0, 100, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 100, 50);
    waitDrain(5);
    run(1);
    checkOutput("final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tvr_scan_ctrl.md
TVR_SCAN_CTRL -- requirements
Module: tvr_scan_ctrl

Interface
REQ-001 The block SHALL have parameter CH_NUM, default 16, giving the number of channels scanned (power of two, 2..256).
REQ-002 The block SHALL have parameter SETTLE_CYC, default 256, giving the clk_in cycles waited after a retune before measuring.
REQ-003 The block SHALL have parameter AVG_LOG2, default 6, giving log2 of the samples per measurement window (1..12).
REQ-004 The block SHALL have parameter HOLD_WIN, default 4, giving the consecutive sub-threshold windows tolerated in LOCK before moving on.
REQ-005 The block SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port scan_en, input, 1 bit: 1 = run scanning; 0 = force IDLE.
REQ-008 The block SHALL have port sample_valid, input, 1 bit: qualifies modulo for one cycle.
REQ-009 The block SHALL have port modulo, input, 12 bits: unsigned demodulator magnitude.
REQ-010 The block SHALL have port thr_gate, input, 24 bits: unsigned carrier-detect threshold.
REQ-011 The block SHALL have port ch_sel, output, log2(CH_NUM) bits: current channel index to the tuner/NCO.
REQ-012 The block SHALL have port ch_load, output, 1 bit: one-cycle strobe that tells the tuner to apply ch_sel.
REQ-013 The block SHALL have port avg_data, output, 24 bits: latest window average, zero-extended.
REQ-014 The block SHALL have port fm_exist, output, 1 bit: 1 while a carrier is locked.
REQ-015 The block SHALL have port audio_mute, output, 1 bit: 1 mutes the audio path; always equals ~fm_exist.
REQ-016 The block SHALL have port busy, output, 1 bit: 1 in any state other than IDLE.

Function
REQ-017 The block SHALL implement FSM states IDLE, TUNE, SETTLE, MEASURE, DECIDE and LOCK; all outputs SHALL be registered.
REQ-018 IDLE SHALL go to TUNE when scan_en=1, keeping ch_sel unchanged.
REQ-019 TUNE SHALL last exactly 1 cycle, assert ch_load during it, clear the accumulator, sample counter and settle counter, then go to SETTLE.
REQ-020 SETTLE SHALL count SETTLE_CYC clk_in cycles regardless of sample_valid, ignore all samples, then go to MEASURE.
REQ-021 MEASURE SHALL add modulo to a 24-bit accumulator on each sample_valid cycle, and go to DECIDE after 2^AVG_LOG2 accepted samples.
REQ-022 The window average SHALL be accumulator >> AVG_LOG2; no overflow is possible because 12+AVG_LOG2 <= 24.
REQ-023 On entry to DECIDE the block SHALL update avg_data with the window average.
REQ-024 DECIDE SHALL last 1 cycle: if average > thr_gate (strictly greater), go to LOCK and set fm_exist=1 on the same edge; otherwise increment ch_sel and go to TUNE.
REQ-025 ch_sel increment SHALL wrap from CH_NUM-1 to 0; the scan SHALL loop indefinitely while no channel qualifies.
REQ-026 LOCK SHALL measure back-to-back windows (no settle) and update avg_data at the end of each window.
REQ-027 In LOCK, a window with average > thr_gate SHALL clear the miss counter; a window at or below thr_gate SHALL increment it.
REQ-028 When the miss counter reaches HOLD_WIN, the block SHALL clear fm_exist, increment ch_sel (with wrap) and go to TUNE on the same edge.
REQ-029 When scan_en=0 in any state, the block SHALL go to IDLE on the next edge, clear fm_exist, clear the counters and keep ch_sel and avg_data.
REQ-030 ch_load SHALL never be asserted outside TUNE, and SHALL never be asserted on two consecutive cycles.
REQ-031 Changes to thr_gate SHALL take effect at the next window decision only.
REQ-032 When sample_valid=1 on the cycle a window completes, that sample SHALL belong to the completing window, not the next one.

Reset
REQ-033 While RST=1 at a clock edge, the block SHALL set the state to IDLE, ch_sel=0, ch_load=0, avg_data=0, fm_exist=0, audio_mute=1, busy=0, and clear all counters, the accumulator and the miss count.
REQ-034 RST SHALL override scan_en, and SHALL abort any state including mid-window.
REQ-035 After RST is released with scan_en=1, the first TUNE SHALL occur on the following edge with ch_sel=0.

Verification (CH_NUM=4, SETTLE_CYC=8, AVG_LOG2=2, HOLD_WIN=2, sample_valid=1 unless stated)
REQ-036 Reset, then scan_en=1, modulo=100, thr_gate=50 -> ch_load pulse at ch_sel=0, then 8 settle cycles and 4 samples; avg_data=100; fm_exist=1, audio_mute=0, no further ch_load.
REQ-037 modulo=10, thr_gate=50 -> ch_sel steps 0,1,2,3,0 with one ch_load per step, 14 cycles apart (1+8+4+1); fm_exist stays 0.
REQ-038 Locked on ch 0, then modulo=10 -> 2 sub-threshold windows (8 samples); fm_exist=0 and ch_load with ch_sel=1; a single good window between the bad ones resets the miss count.
REQ-039 modulo=50, thr_gate=50 (equal) -> no lock; modulo=51 -> lock.
REQ-040 sample_valid toggling 1/0 during MEASURE -> the window completes after 4 valid samples (8 cycles); avg_data equals the mean of the valid samples only.
REQ-041 scan_en=0 mid-SETTLE and RST=1 mid-LOCK -> IDLE next edge; fm_exist=0; ch_sel is retained after scan_en=0 and is 0 after RST.
